// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the two-port RAM arbiter: FSM states, port ids, op codes
// and the default abort data returned when the RAM never answers.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1
  } state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic [31:0] DEFAULT_ABORT_DATA = 32'hdeadbeef;

endpackage

// File: rtl/ram_arb_req_latch.sv
// Per-port request capture: holds one pending request (addr, wdata, op) until
// the arbiter core clears it, and flags malformed or overlapping requests.
module ram_arb_req_latch
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          read_req,
  input  logic          write_req,
  input  logic          clr,
  output logic          pend,
  output logic [AW-1:0] lat_addr,
  output logic [DW-1:0] lat_wdata,
  output logic          lat_op,
  output logic          proto_err
);

  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          op_q, op_d;
  logic          req, busy, accept;

  always_comb begin
    req    = read_req | write_req;
    // A request arriving on the edge its predecessor completes is accepted.
    busy   = pend_q & ~clr;
    accept = req & ~busy;

    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    if (clr) pend_d = 1'b0;
    if (accept) begin
      pend_d  = 1'b1;
      addr_d  = addr;
      wdata_d = wdata;
      op_d    = read_req ? OP_READ : OP_WRITE;
    end
    proto_err = (req & busy) | (read_req & write_req);
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    op_q    <= op_d;
  end

  assign pend      = pend_q;
  assign lat_addr  = addr_q;
  assign lat_wdata = wdata_q;
  assign lat_op    = op_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one pulse-handshake RAM port between the CPU
// (port 0) and the loader/DMA (port 1), with a timeout for a silent RAM.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int          AW         = 32,
  parameter int          DW         = 32,
  parameter int          TIMEOUT    = 255,
  parameter logic [DW-1:0] ABORT_DATA = DW'(DEFAULT_ABORT_DATA)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p0_read_req,
  input  logic          p0_write_req,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_read_ack,
  output logic          p0_write_ack,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_read_req,
  input  logic          p1_write_req,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_read_ack,
  output logic          p1_write_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read_req,
  output logic          mem_write_req,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_read_ack,
  input  logic          mem_write_ack,
  output logic          owner,
  output logic          err_proto,
  output logic          err_timeout
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic          pend0, pend1, op0, op1, perr0, perr1, clr0, clr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  ram_arb_req_latch #(.AW(AW), .DW(DW)) u_lat0 (
    .clk(clk), .reset(reset), .addr(p0_addr), .wdata(p0_wdata),
    .read_req(p0_read_req), .write_req(p0_write_req), .clr(clr0),
    .pend(pend0), .lat_addr(addr0), .lat_wdata(wdata0), .lat_op(op0),
    .proto_err(perr0)
  );

  ram_arb_req_latch #(.AW(AW), .DW(DW)) u_lat1 (
    .clk(clk), .reset(reset), .addr(p1_addr), .wdata(p1_wdata),
    .read_req(p1_read_req), .write_req(p1_write_req), .clr(clr1),
    .pend(pend1), .lat_addr(addr1), .lat_wdata(wdata1), .lat_op(op1),
    .proto_err(perr1)
  );

  state_t        state_q, state_d;
  logic          owner_q, owner_d, last_q, last_d, cur_op_q, cur_op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic          p0_rack_q, p0_rack_d, p0_wack_q, p0_wack_d;
  logic          p1_rack_q, p1_rack_d, p1_wack_q, p1_wack_d;
  logic          err_proto_q, err_proto_d, err_to_q, err_to_d;
  // Set when reset abandons a WAIT, so the orphaned RAM ack is swallowed quietly.
  logic          stale_q, stale_d;
  logic          grant, match, wrong, expired;
  logic [DW-1:0] rdata_val;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cur_op_d    = cur_op_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_rack_d   = 1'b0;
    p0_wack_d   = 1'b0;
    p1_rack_d   = 1'b0;
    p1_wack_d   = 1'b0;
    err_proto_d = err_proto_q | perr0 | perr1;
    err_to_d    = err_to_q;
    stale_d     = stale_q;
    clr0        = 1'b0;
    clr1        = 1'b0;
    grant       = PORT_CPU;
    match       = 1'b0;
    wrong       = 1'b0;
    expired     = 1'b0;
    rdata_val   = mem_rdata;

    case (state_q)
      ST_IDLE: begin
        if (mem_read_ack | mem_write_ack) begin
          if (stale_q) stale_d = 1'b0;
          else         err_proto_d = 1'b1;
        end
        if (pend0 | pend1) begin
          grant       = (pend0 & pend1) ? ~last_q : pend1;
          owner_d     = grant;
          cur_op_d    = grant ? op1 : op0;
          mem_addr_d  = grant ? addr1 : addr0;
          mem_wdata_d = grant ? wdata1 : wdata0;
          mem_rd_d    = (cur_op_d == OP_READ);
          mem_wr_d    = (cur_op_d == OP_WRITE);
          cnt_d       = '0;
          stale_d     = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        match   = (cur_op_q == OP_READ) ? mem_read_ack : mem_write_ack;
        wrong   = (cur_op_q == OP_READ) ? mem_write_ack : mem_read_ack;
        expired = (cnt_q == CW'(TIMEOUT - 1));
        if (wrong) err_proto_d = 1'b1;
        if (match | expired) begin
          rdata_val = match ? mem_rdata : ABORT_DATA;
          if (!match) err_to_d = 1'b1;
          if (owner_q == PORT_CPU) begin
            clr0      = 1'b1;
            p0_rack_d = (cur_op_q == OP_READ);
            p0_wack_d = (cur_op_q == OP_WRITE);
            if (cur_op_q == OP_READ) p0_rdata_d = rdata_val;
          end else begin
            clr1      = 1'b1;
            p1_rack_d = (cur_op_q == OP_READ);
            p1_wack_d = (cur_op_q == OP_WRITE);
            if (cur_op_q == OP_READ) p1_rdata_d = rdata_val;
          end
          last_d  = owner_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= PORT_CPU;
      last_q      <= PORT_LOAD;
      cur_op_q    <= OP_READ;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_rack_q   <= 1'b0;
      p0_wack_q   <= 1'b0;
      p1_rack_q   <= 1'b0;
      p1_wack_q   <= 1'b0;
      err_proto_q <= 1'b0;
      err_to_q    <= 1'b0;
      stale_q     <= stale_q | (state_q == ST_WAIT);
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cur_op_q    <= cur_op_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_rack_q   <= p0_rack_d;
      p0_wack_q   <= p0_wack_d;
      p1_rack_q   <= p1_rack_d;
      p1_wack_q   <= p1_wack_d;
      err_proto_q <= err_proto_d;
      err_to_q    <= err_to_d;
      stale_q     <= stale_d;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_read_req  = mem_rd_q;
  assign mem_write_req = mem_wr_q;
  assign p0_rdata      = p0_rdata_q;
  assign p1_rdata      = p1_rdata_q;
  assign p0_read_ack   = p0_rack_q;
  assign p0_write_ack  = p0_wack_q;
  assign p1_read_ack   = p1_rack_q;
  assign p1_write_ack  = p1_wack_q;
  assign owner         = owner_q;
  assign err_proto     = err_proto_q;
  assign err_timeout   = err_to_q;

endmodule
